// File: rtl/vip_axi4_wr_slave.sv
// AXI4 write-channel slave with an internal word-addressed memory and a
// one-cycle-latency backdoor read port; one burst in flight at a time.
module vip_axi4_wr_slave #(
    parameter int ID_WIDTH_P   = 4,
    parameter int ADDR_WIDTH_P = 16,
    parameter int DATA_WIDTH_P = 32,
    parameter int MEM_DEPTH_P  = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ID_WIDTH_P-1:0]          awid,
    input  logic [ADDR_WIDTH_P-1:0]        awaddr,
    input  logic [7:0]                     awlen,
    input  logic [2:0]                     awsize,
    input  logic [1:0]                     awburst,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH_P-1:0]        wdata,
    input  logic [DATA_WIDTH_P/8-1:0]      wstrb,
    input  logic                           wlast,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [ID_WIDTH_P-1:0]          bid,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [$clog2(MEM_DEPTH_P)-1:0] mem_raddr,
    output logic [DATA_WIDTH_P-1:0]        mem_rdata
);

    localparam int STRB_W = DATA_WIDTH_P / 8;
    localparam int SIZE_L = $clog2(STRB_W);
    localparam int MIDX_W = $clog2(MEM_DEPTH_P);
    // One extra bit so an INCR burst running off the top of the address
    // space is still seen as out of range rather than wrapping to word 0.
    localparam int WIDX_W = ADDR_WIDTH_P + 1;
    localparam logic [WIDX_W-1:0] DEPTH_L   = WIDX_W'(MEM_DEPTH_P);
    localparam logic [2:0]        SIZE_OK_L = 3'(SIZE_L);
    localparam logic [1:0]        BURST_FIXED = 2'b00;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ID_WIDTH_P-1:0]    id_q, id_d;
    logic [WIDX_W-1:0]        idx_q, idx_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               count_q, count_d;
    logic                     fixed_q, fixed_d;
    logic                     noWrite_q, noWrite_d;
    logic                     slvErr_q, slvErr_d;
    logic                     decErr_q, decErr_d;

    logic [DATA_WIDTH_P-1:0]  mem_q [MEM_DEPTH_P];
    logic [DATA_WIDTH_P-1:0]  rdata_q;

    logic                     wBeat;
    logic                     inRange;
    logic                     lastBeat;
    logic                     memWe;

    assign wBeat    = (state_q == DATA) && wvalid && !rst;
    assign inRange  = (idx_q < DEPTH_L);
    assign lastBeat = (count_q == len_q);
    assign memWe    = wBeat && inRange && !noWrite_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            count_q   <= '0;
            fixed_q   <= 1'b0;
            noWrite_q <= 1'b0;
            slvErr_q  <= 1'b0;
            decErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            count_q   <= count_d;
            fixed_q   <= fixed_d;
            noWrite_q <= noWrite_d;
            slvErr_q  <= slvErr_d;
            decErr_q  <= decErr_d;
        end
    end

    // All handshake outputs are forced low while rst is high, whatever state
    // the register still holds during that first reset cycle.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        idx_d     = idx_q;
        len_d     = len_q;
        count_d   = count_q;
        fixed_d   = fixed_q;
        noWrite_d = noWrite_q;
        slvErr_d  = slvErr_q;
        decErr_d  = decErr_q;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = RESP_OKAY;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    awready = 1'b1;
                    if (awvalid) begin
                        id_d      = awid;
                        idx_d     = {1'b0, awaddr} >> SIZE_L;
                        len_d     = awlen;
                        count_d   = '0;
                        fixed_d   = (awburst == BURST_FIXED);
                        noWrite_d = awburst[1] || (awsize != SIZE_OK_L);
                        slvErr_d  = awburst[1] || (awsize != SIZE_OK_L);
                        decErr_d  = 1'b0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        count_d = count_q + 8'd1;
                        if (!fixed_q) begin
                            idx_d = idx_q + WIDX_W'(1);
                        end
                        if (!inRange) begin
                            decErr_d = 1'b1;
                        end
                        if (wlast != lastBeat) begin
                            slvErr_d = 1'b1;
                        end
                        if (lastBeat) begin
                            state_d = RESP;
                        end
                    end
                end
                RESP: begin
                    bvalid = 1'b1;
                    bid    = id_q;
                    bresp  = decErr_q ? RESP_DECERR :
                             slvErr_q ? RESP_SLVERR : RESP_OKAY;
                    if (bready) begin
                        slvErr_d = 1'b0;
                        decErr_d = 1'b0;
                        count_d  = '0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory is deliberately left out of reset; the backdoor read samples
    // the array before this edge's byte writes land, so it sees old data.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[idx_q[MIDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[mem_raddr];
    end

    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_vip_axi4_wr_slave.sv
// Directed bench for vip_axi4_wr_slave: a table of bursts with hand-computed
// responses and memory contents, plus sequences for stall, reset and read timing.
module tb_vip_axi4_wr_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    vip_axi4_wr_slave dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       id;
        logic [15:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][31:0] data;
        logic [3:0][3:0]  strb;
        int               wlastAt;
        logic [1:0]       expResp;
        logic [7:0]       idx0;
        logic [31:0]      exp0;
        logic [7:0]       idx1;
        logic [31:0]      exp1;
    } vec_t;

    vec_t vecs[9];

    function automatic void compare(input string name, input logic [63:0] act,
                                    input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: handshake never happened within the cycle budget", name);
    endfunction

    function automatic vec_t mkVec(
        input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [31:0] d2, input logic [31:0] d3,
        input logic [3:0] s0, input logic [3:0] s1,
        input logic [3:0] s2, input logic [3:0] s3,
        input int wlastAt, input logic [1:0] expResp,
        input logic [7:0] idx0, input logic [31:0] exp0,
        input logic [7:0] idx1, input logic [31:0] exp1);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.strb[0] = s0; v.strb[1] = s1; v.strb[2] = s2; v.strb[3] = s3;
        v.wlastAt = wlastAt; v.expResp = expResp;
        v.idx0 = idx0; v.exp0 = exp0; v.idx1 = idx1; v.exp1 = exp1;
        return v;
    endfunction

    // Every task starts and ends on a falling edge.
    task automatic sendAw(input logic [3:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!awready) timeoutFail("aw_timeout");
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wready) timeoutFail("w_timeout");
        @(negedge clk);
    endtask

    task automatic waitB(input string name, input logic [3:0] expId,
                         input logic [1:0] expResp);
        int n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            timeoutFail({name, "_b_timeout"});
        end else begin
            compare({name, "_bid"}, 64'(bid), 64'(expId));
            compare({name, "_bresp"}, 64'(bresp), 64'(expResp));
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            compare({name, "_awready_after_b"}, 64'(awready), 64'd1);
        end
    endtask

    task automatic readWord(input logic [7:0] idx, output logic [31:0] val);
        mem_raddr = idx;
        @(negedge clk);
        val = mem_rdata;
    endtask

    task automatic applyStimulus(input vec_t v);
        sendAw(v.id, v.addr, v.len, v.size, v.burst);
        for (int b = 0; b <= int'(v.len); b++) begin
            sendW(v.data[b], v.strb[b], b == v.wlastAt);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic checkOutput(input int k, input vec_t v);
        logic [31:0] val;
        string tag;
        tag = $sformatf("vec%0d", k);
        waitB(tag, v.id, v.expResp);
        readWord(v.idx0, val);
        compare({tag, "_word_a"}, 64'(val), 64'(v.exp0));
        readWord(v.idx1, val);
        compare({tag, "_word_b"}, 64'(val), 64'(v.exp1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] val;

        vecs[0] = mkVec(4'h1, 16'h0000, 8'd0, 3'd2, 2'b01,
                        32'h55AA55AA, 0, 0, 0, 4'hF, 0, 0, 0, 0, 2'b00,
                        8'd0, 32'h55AA55AA, 8'd0, 32'h55AA55AA);
        vecs[1] = mkVec(4'h3, 16'h0010, 8'd3, 3'd2, 2'b01,
                        32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 4'hF, 4'hF, 4'hF, 3, 2'b00,
                        8'd4, 32'hA0, 8'd7, 32'hA3);
        vecs[2] = mkVec(4'h5, 16'h0008, 8'd1, 3'd2, 2'b00,
                        32'h11223344, 32'hFFFFFFFF, 0, 0, 4'hF, 4'h1, 0, 0, 1, 2'b00,
                        8'd2, 32'h112233FF, 8'd2, 32'h112233FF);
        vecs[3] = mkVec(4'h6, 16'h03FC, 8'd1, 3'd2, 2'b01,
                        32'hDEAD0001, 32'hDEAD0002, 0, 0, 4'hF, 4'hF, 0, 0, 1, 2'b11,
                        8'd255, 32'hDEAD0001, 8'd0, 32'h55AA55AA);
        vecs[4] = mkVec(4'h7, 16'h0040, 8'd3, 3'd2, 2'b01,
                        32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'hF, 4'hF, 4'hF, 4'hF, 1, 2'b10,
                        8'd16, 32'hB0, 8'd19, 32'hB3);
        vecs[5] = mkVec(4'h8, 16'h0010, 8'd1, 3'd2, 2'b10,
                        32'hC0, 32'hC1, 0, 0, 4'hF, 4'hF, 0, 0, 1, 2'b10,
                        8'd4, 32'hA0, 8'd5, 32'hA1);
        vecs[6] = mkVec(4'hA, 16'h0018, 8'd1, 3'd1, 2'b01,
                        32'hD0, 32'hD1, 0, 0, 4'hF, 4'hF, 0, 0, 1, 2'b10,
                        8'd6, 32'hA2, 8'd7, 32'hA3);
        vecs[7] = mkVec(4'hB, 16'h0014, 8'd0, 3'd2, 2'b01,
                        32'h12345678, 0, 0, 0, 4'h6, 0, 0, 0, 0, 2'b00,
                        8'd5, 32'h003456A1, 8'd4, 32'hA0);
        vecs[8] = mkVec(4'hF, 16'h0400, 8'd0, 3'd2, 2'b00,
                        32'hEE, 0, 0, 0, 4'hF, 0, 0, 0, 0, 2'b11,
                        8'd0, 32'h55AA55AA, 8'd255, 32'hDEAD0001);

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1;
        bready = 1'b0; mem_raddr = '0;
        repeat (3) @(negedge clk);
        compare("reset_awready", 64'(awready), 64'd0);
        compare("reset_wready", 64'(wready), 64'd0);
        compare("reset_bvalid", 64'(bvalid), 64'd0);
        compare("reset_bid_bresp", 64'({bid, bresp}), 64'd0);
        awvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        compare("awready_after_reset", 64'(awready), 64'd1);

        // W presented ahead of AW must not be taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("early_w_wready", 64'(wready), 64'd0);
        end
        wvalid = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            applyStimulus(vecs[k]);
            checkOutput(k, vecs[k]);
        end

        // Response held while bready stays low.
        sendAw(4'h9, 16'h0080, 8'd0, 3'd2, 2'b01);
        sendW(32'h77, 4'hF, 1'b1);
        wvalid = 1'b0; wlast = 1'b0;
        awvalid = 1'b1; awid = 4'h2; awaddr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compare("stall_bvalid", 64'(bvalid), 64'd1);
            compare("stall_bid", 64'(bid), 64'h9);
            compare("stall_bresp", 64'(bresp), 64'd0);
            compare("stall_awready", 64'(awready), 64'd0);
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        compare("stall_release_awready", 64'(awready), 64'd1);

        // Backdoor read racing a write to the same word returns old data.
        sendAw(4'h4, 16'h0080, 8'd0, 3'd2, 2'b01);
        mem_raddr = 8'd32;
        sendW(32'h88, 4'hF, 1'b1);
        wvalid = 1'b0; wlast = 1'b0;
        compare("read_during_write_old", 64'(mem_rdata), 64'h77);
        @(negedge clk);
        compare("read_after_write_new", 64'(mem_rdata), 64'h88);
        waitB("rdw", 4'h4, 2'b00);

        // Reset in the middle of a burst: no response, AW open again at once.
        sendAw(4'h2, 16'h0100, 8'd3, 3'd2, 2'b01);
        sendW(32'h99, 4'hF, 1'b0);
        wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        compare("midreset_wready", 64'(wready), 64'd0);
        compare("midreset_awready", 64'(awready), 64'd0);
        compare("midreset_bvalid", 64'(bvalid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        compare("midreset_awready_after", 64'(awready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("midreset_no_bvalid", 64'(bvalid), 64'd0);
        end
        readWord(8'd64, val);
        compare("midreset_first_beat_kept", 64'(val), 64'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
